// File: rtl/adc_spi_chan_model.sv
// Multi-channel ADC128S-style A2D model with an SPI mode-0 slave port.
// Channels are bench-writable; optional per-conversion ramp and address-error diagnostics.
module adc_spi_chan_model #(
    parameter int NUM_CH    = 8,
    parameter int DATA_W    = 12,
    parameter int RAMP_STEP = 1,
    parameter int SYNC_STG  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              SCLK,
    input  logic              MOSI,
    output logic              MISO,
    input  logic              wr_en,
    input  logic [2:0]        wr_ch,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [1:0]        mode,
    output logic              frame_done,
    output logic [2:0]        last_ch,
    output logic              addr_err,
    output logic [15:0]       conv_cnt,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} state_t;

    // SPI handshake: SS_n falling starts a frame, MOSI is sampled on SCLK rising,
    // MISO advances on SCLK falling, SS_n rising ends the frame.
    state_t                state_q, state_d;
    logic [SYNC_STG-1:0]   ss_sync_q, ss_sync_d;
    logic [SYNC_STG-1:0]   sclk_sync_q, sclk_sync_d;
    logic [SYNC_STG-1:0]   mosi_sync_q, mosi_sync_d;
    logic                  ss_prev_q, ss_prev_d;
    logic                  sclk_prev_q, sclk_prev_d;
    logic [15:0]           tx_q, tx_d;
    // Only the low 14 received bits matter: the address sits at frame bits 13:11.
    logic [13:0]           rx_q, rx_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [2:0]            ptr_q, ptr_d;
    logic [DATA_W-1:0]     chan_q [8];
    logic [DATA_W-1:0]     chan_d [8];
    logic                  frame_done_q, frame_done_d;
    logic                  addr_err_q, addr_err_d;
    logic [2:0]            last_ch_q, last_ch_d;
    logic [15:0]           conv_cnt_q, conv_cnt_d;

    logic                  ss_s, sclk_s, mosi_s;
    logic                  ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic [2:0]            req_ch;
    logic                  req_ok;
    logic [DATA_W:0]       ramp_sum;

    assign ss_s      = ss_sync_q[SYNC_STG-1];
    assign sclk_s    = sclk_sync_q[SYNC_STG-1];
    assign mosi_s    = mosi_sync_q[SYNC_STG-1];
    assign ss_fall   = ss_prev_q & ~ss_s;
    assign ss_rise   = ~ss_prev_q & ss_s;
    assign sclk_rise = ~sclk_prev_q & sclk_s;
    assign sclk_fall = sclk_prev_q & ~sclk_s;
    assign req_ch    = rx_q[13:11];
    assign req_ok    = ({1'b0, req_ch} < 4'(NUM_CH));
    assign ramp_sum  = {1'b0, chan_q[ptr_q]} + (DATA_W+1)'(RAMP_STEP);

    always_comb begin
        state_d      = state_q;
        ss_sync_d    = {ss_sync_q[SYNC_STG-2:0], SS_n};
        sclk_sync_d  = {sclk_sync_q[SYNC_STG-2:0], SCLK};
        mosi_sync_d  = {mosi_sync_q[SYNC_STG-2:0], MOSI};
        ss_prev_d    = ss_s;
        sclk_prev_d  = sclk_s;
        tx_d         = tx_q;
        rx_d         = rx_q;
        bit_cnt_d    = bit_cnt_q;
        ptr_d        = ptr_q;
        chan_d       = chan_q;
        frame_done_d = 1'b0;
        addr_err_d   = 1'b0;
        last_ch_d    = last_ch_q;
        conv_cnt_d   = conv_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (ss_fall) begin
                    tx_d      = 16'(chan_q[ptr_q]);
                    bit_cnt_d = 5'd0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sclk_rise) begin
                    rx_d = {rx_q[12:0], mosi_s};
                    if (bit_cnt_q != 5'd16) bit_cnt_d = bit_cnt_q + 5'd1;
                end
                if (sclk_fall) tx_d = {tx_q[14:0], 1'b0};
                if (ss_rise) state_d = (bit_cnt_q == 5'd16) ? ST_COMMIT : ST_IDLE;
            end
            ST_COMMIT: begin
                frame_done_d = 1'b1;
                last_ch_d    = ptr_q;
                conv_cnt_d   = conv_cnt_q + 16'd1;
                if (req_ok) ptr_d = req_ch;
                else if (mode == 2'b11) addr_err_d = 1'b1;
                // Ramp applies to the channel just served, before the pointer moves.
                if (mode == 2'b01) chan_d[ptr_q] = ramp_sum[DATA_W-1:0];
                else if (mode == 2'b10) chan_d[ptr_q] = ramp_sum[DATA_W] ? '1 : ramp_sum[DATA_W-1:0];
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Bench writes come last so they win over a same-cycle ramp update.
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (i < NUM_CH && wr_ch == 3'(i)) chan_d[i] = wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ss_sync_q    <= '1;
            sclk_sync_q  <= '0;
            mosi_sync_q  <= '0;
            ss_prev_q    <= 1'b1;
            sclk_prev_q  <= 1'b0;
            tx_q         <= '0;
            rx_q         <= '0;
            bit_cnt_q    <= '0;
            ptr_q        <= '0;
            chan_q       <= '{default: '0};
            frame_done_q <= 1'b0;
            addr_err_q   <= 1'b0;
            last_ch_q    <= '0;
            conv_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            ss_sync_q    <= ss_sync_d;
            sclk_sync_q  <= sclk_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            ss_prev_q    <= ss_prev_d;
            sclk_prev_q  <= sclk_prev_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            bit_cnt_q    <= bit_cnt_d;
            ptr_q        <= ptr_d;
            chan_q       <= chan_d;
            frame_done_q <= frame_done_d;
            addr_err_q   <= addr_err_d;
            last_ch_q    <= last_ch_d;
            conv_cnt_q   <= conv_cnt_d;
        end
    end

    assign MISO       = (state_q == ST_SHIFT) & tx_q[15];
    assign frame_done = frame_done_q;
    assign addr_err   = addr_err_q;
    assign last_ch    = last_ch_q;
    assign conv_cnt   = conv_cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_adc_spi_chan_model.sv
// Directed bench for adc_spi_chan_model: a frame table plus hand sequences for
// address errors, aborted frames and mid-frame reset. A 4-channel copy shares the bus.
module tb_adc_spi_chan_model;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ss_n = 1'b1;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_ch = '0;
    logic [11:0] wr_data = '0;
    logic [1:0]  mode = 2'b00;

    logic        miso8, fd8_o, ae8_o, miso4, fd4_o, ae4_o;
    logic [2:0]  last8, last4;
    logic [15:0] cnt8, cnt4;
    logic [1:0]  dbg8, dbg4;

    int n_vec = 0;
    int n_err = 0;
    int fd8 = 0;
    int ae8 = 0;
    int ae4 = 0;

    always #5 clk = ~clk;

    adc_spi_chan_model u8 (
        .clk(clk), .rst(rst), .SS_n(ss_n), .SCLK(sclk), .MOSI(mosi), .MISO(miso8),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data), .mode(mode),
        .frame_done(fd8_o), .last_ch(last8), .addr_err(ae8_o), .conv_cnt(cnt8),
        .dbg_state(dbg8)
    );

    adc_spi_chan_model #(.NUM_CH(4)) u4 (
        .clk(clk), .rst(rst), .SS_n(ss_n), .SCLK(sclk), .MOSI(mosi), .MISO(miso4),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data), .mode(mode),
        .frame_done(fd4_o), .last_ch(last4), .addr_err(ae4_o), .conv_cnt(cnt4),
        .dbg_state(dbg4)
    );

    always @(posedge clk) begin
        if (fd8_o) fd8 <= fd8 + 1;
        if (ae8_o) ae8 <= ae8 + 1;
        if (ae4_o) ae4 <= ae4 + 1;
    end

    typedef struct {
        logic        do_wr;
        logic [2:0]  wr_ch;
        logic [11:0] wr_data;
        logic [1:0]  mode;
        logic [2:0]  addr;
        logic [15:0] exp_miso;
        logic [2:0]  exp_last;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[10];

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic write_ch(input logic [2:0] ch, input logic [11:0] data);
        wr_en = 1'b1; wr_ch = ch; wr_data = data;
        wait_clk(1);
        wr_en = 1'b0;
    endtask

    task automatic spi_frame(input logic [2:0] addr, input int nbits, input bit end_frame,
                             output logic [15:0] rx8, output logic [15:0] rx4);
        logic [15:0] cmd;
        cmd = {2'b00, addr, 11'b0};
        rx8 = '0;
        rx4 = '0;
        ss_n = 1'b0;
        wait_clk(8);
        for (int i = 0; i < nbits; i++) begin
            mosi = cmd[15-i];
            wait_clk(4);
            rx8[15-i] = miso8;
            rx4[15-i] = miso4;
            sclk = 1'b1;
            wait_clk(8);
            sclk = 1'b0;
            wait_clk(4);
        end
        if (end_frame) begin
            wait_clk(4);
            ss_n = 1'b1;
            mosi = 1'b0;
            wait_clk(12);
        end
    endtask

    initial begin
        logic [15:0] r8, r4;
        int fd_before, ae8_before, ae4_before;

        vecs[0] = '{1'b1, 3'd0, 12'h123, 2'b00, 3'd0, 16'h0123, 3'd0, 16'd1};
        vecs[1] = '{1'b1, 3'd3, 12'hABC, 2'b00, 3'd3, 16'h0123, 3'd0, 16'd2};
        vecs[2] = '{1'b1, 3'd4, 12'h400, 2'b00, 3'd4, 16'h0ABC, 3'd3, 16'd3};
        vecs[3] = '{1'b0, 3'd0, 12'h000, 2'b00, 3'd7, 16'h0400, 3'd4, 16'd4};
        vecs[4] = '{1'b1, 3'd2, 12'hFFF, 2'b00, 3'd2, 16'h0000, 3'd7, 16'd5};
        vecs[5] = '{1'b0, 3'd0, 12'h000, 2'b00, 3'd2, 16'h0FFF, 3'd2, 16'd6};
        vecs[6] = '{1'b0, 3'd0, 12'h000, 2'b01, 3'd2, 16'h0FFF, 3'd2, 16'd7};
        vecs[7] = '{1'b0, 3'd0, 12'h000, 2'b01, 3'd2, 16'h0000, 3'd2, 16'd8};
        vecs[8] = '{1'b1, 3'd2, 12'hFFF, 2'b10, 3'd2, 16'h0FFF, 3'd2, 16'd9};
        vecs[9] = '{1'b0, 3'd0, 12'h000, 2'b10, 3'd2, 16'h0FFF, 3'd2, 16'd10};

        wait_clk(5);
        rst = 1'b0;
        wait_clk(2);
        check("reset miso", 32'(miso8), 32'h0);
        check("reset frame_done", 32'(fd8_o), 32'h0);
        check("reset addr_err", 32'(ae8_o), 32'h0);
        check("reset last_ch", 32'(last8), 32'h0);
        check("reset conv_cnt", 32'(cnt8), 32'h0);

        for (int i = 0; i < 10; i++) begin
            mode = vecs[i].mode;
            if (vecs[i].do_wr) write_ch(vecs[i].wr_ch, vecs[i].wr_data);
            fd_before = fd8;
            spi_frame(vecs[i].addr, 16, 1'b1, r8, r4);
            check($sformatf("v%0d miso", i), 32'(r8), 32'(vecs[i].exp_miso));
            check($sformatf("v%0d last_ch", i), 32'(last8), 32'(vecs[i].exp_last));
            check($sformatf("v%0d conv_cnt", i), 32'(cnt8), 32'(vecs[i].exp_cnt));
            check($sformatf("v%0d frame_done", i), 32'(fd8 - fd_before), 32'd1);
        end

        // Address-error diagnostics on the 4-channel instance
        mode = 2'b11;
        write_ch(3'd1, 12'h111);
        spi_frame(3'd1, 16, 1'b1, r8, r4);
        check("ae setup miso", 32'(r8), 32'h0FFF);
        ae8_before = ae8;
        ae4_before = ae4;
        spi_frame(3'd6, 16, 1'b1, r8, r4);
        check("ae req miso4", 32'(r4), 32'h0111);
        check("ae pulse4", 32'(ae4 - ae4_before), 32'd1);
        check("ae none8", 32'(ae8 - ae8_before), 32'd0);
        spi_frame(3'd0, 16, 1'b1, r8, r4);
        check("ae after miso4", 32'(r4), 32'h0111);
        check("ae after last4", 32'(last4), 32'd1);
        check("ae after miso8", 32'(r8), 32'h0000);
        check("ae conv_cnt", 32'(cnt8), 32'd13);

        // Aborted frame after 9 SCLK edges
        mode = 2'b00;
        write_ch(3'd5, 12'h555);
        fd_before = fd8;
        spi_frame(3'd5, 9, 1'b1, r8, r4);
        check("abort frame_done", 32'(fd8 - fd_before), 32'd0);
        check("abort conv_cnt", 32'(cnt8), 32'd13);
        spi_frame(3'd3, 16, 1'b1, r8, r4);
        check("abort next miso", 32'(r8), 32'h0123);
        check("abort next last_ch", 32'(last8), 32'd0);
        check("abort next conv_cnt", 32'(cnt8), 32'd14);

        // Reset in the middle of a frame
        spi_frame(3'd2, 5, 1'b0, r8, r4);
        fd_before = fd8;
        rst = 1'b1;
        ss_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(4);
        check("mid rst conv_cnt", 32'(cnt8), 32'd0);
        check("mid rst last_ch", 32'(last8), 32'd0);
        check("mid rst miso", 32'(miso8), 32'd0);
        check("mid rst frame_done", 32'(fd8 - fd_before), 32'd0);
        spi_frame(3'd0, 16, 1'b1, r8, r4);
        check("post rst miso", 32'(r8), 32'h0000);
        check("post rst conv_cnt", 32'(cnt8), 32'd1);
        check("post rst frame_done", 32'(fd8 - fd_before), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
